// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: merges power-on, external and software reset
// sources and releases NUM_CH active-low resets one at a time in index order.
module reset_sequencer #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned HOLD_TICKS  = 32,
  parameter int unsigned STAGE_TICKS = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              ext_rst_n,
  input  logic              sw_rst_req,
  output logic [NUM_CH-1:0] rst_n_out,
  output logic              busy,
  output logic [1:0]        rst_cause
);

  generate
    if (NUM_CH < 1) begin : g_bad_num_ch
      $fatal(1, "reset_sequencer: NUM_CH must be >= 1");
    end
    if (HOLD_TICKS < 1) begin : g_bad_hold
      $fatal(1, "reset_sequencer: HOLD_TICKS must be >= 1");
    end
    if (STAGE_TICKS < 1) begin : g_bad_stage
      $fatal(1, "reset_sequencer: STAGE_TICKS must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $fatal(1, "reset_sequencer: SYNC_STAGES must be >= 2");
    end
  endgenerate

  localparam int unsigned MAX_TICKS = (HOLD_TICKS > STAGE_TICKS) ? HOLD_TICKS : STAGE_TICKS;
  localparam int unsigned CNT_W     = $clog2(MAX_TICKS + 1);
  localparam int unsigned IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Counter runs down to zero, so a reload of TICKS-1 spans exactly TICKS edges.
  localparam logic [CNT_W-1:0] HOLD_RELOAD  = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] STAGE_RELOAD = CNT_W'(STAGE_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE      = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_CH - 1);

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_EXT = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RELEASE,
    ST_RUN
  } state_t;

  logic [SYNC_STAGES-1:0] por_sync;
  logic [SYNC_STAGES-1:0] ext_sync;
  logic                   por_hold;
  logic                   ext_req;

  state_t             state,     state_nxt;
  logic [CNT_W-1:0]   cnt,       cnt_nxt;
  logic [IDX_W-1:0]   idx,       idx_nxt;
  logic [NUM_CH-1:0]  out_nxt;
  logic               busy_nxt;
  logic [1:0]         cause_nxt;

  // Both chains assert with rst_in; the external one idles at "not requested".
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      por_sync <= '1;
      ext_sync <= '1;
    end else begin
      por_sync <= {por_sync[SYNC_STAGES-2:0], 1'b0};
      ext_sync <= {ext_sync[SYNC_STAGES-2:0], ext_rst_n};
    end
  end

  assign por_hold = por_sync[SYNC_STAGES-1];
  assign ext_req  = ~ext_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state     <= ST_HOLD;
      cnt       <= HOLD_RELOAD;
      idx       <= '0;
      rst_n_out <= '0;
      busy      <= 1'b1;
      rst_cause <= CAUSE_POR;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      rst_n_out <= out_nxt;
      busy      <= busy_nxt;
      rst_cause <= cause_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    out_nxt   = rst_n_out;
    cause_nxt = rst_cause;

    unique case (state)
      ST_HOLD: begin
        out_nxt = '0;
        if (ext_req) begin
          cnt_nxt   = HOLD_RELOAD;
          cause_nxt = CAUSE_EXT;
        end else if (!por_hold) begin
          if (cnt == '0) begin
            out_nxt[0] = 1'b1;
            cnt_nxt    = STAGE_RELOAD;
            idx_nxt    = IDX_ONE;
            state_nxt  = (NUM_CH == 1) ? ST_RUN : ST_RELEASE;
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
      end
      ST_RELEASE: begin
        if (cnt == '0) begin
          out_nxt[idx] = 1'b1;
          cnt_nxt      = STAGE_RELOAD;
          idx_nxt      = idx + IDX_ONE;
          if (idx == LAST_IDX) begin
            state_nxt = ST_RUN;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      ST_RUN: begin
      end
      default: begin
        state_nxt = ST_HOLD;
        out_nxt   = '0;
        cnt_nxt   = HOLD_RELOAD;
        idx_nxt   = '0;
      end
    endcase

    // Retrigger overrides the sequencing above; external takes priority over software.
    if ((state != ST_HOLD) && (ext_req || sw_rst_req)) begin
      state_nxt = ST_HOLD;
      out_nxt   = '0;
      cnt_nxt   = HOLD_RELOAD;
      idx_nxt   = '0;
      cause_nxt = ext_req ? CAUSE_EXT : CAUSE_SW;
    end

    busy_nxt = (state_nxt != ST_RUN);
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: default and minimal parameter sets
// side by side, timing tables, directed corner cases and random stimulus.
module tb_reset_sequencer;

  localparam int A_NCH = 4, A_H = 32, A_ST = 16, A_S = 2;
  localparam int B_NCH = 1, B_H = 1,  B_ST = 1,  B_S = 3;
  localparam int HIST  = 16384;

  logic clk = 1'b0;
  logic rst_in, ext_rst_n, sw_rst_req;
  logic [A_NCH-1:0] a_out;
  logic             a_busy;
  logic [1:0]       a_cause;
  logic [B_NCH-1:0] b_out;
  logic             b_busy;
  logic [1:0]       b_cause;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reset_sequencer #(.NUM_CH(A_NCH), .HOLD_TICKS(A_H), .STAGE_TICKS(A_ST), .SYNC_STAGES(A_S)) u_a (
    .clk(clk), .rst_in(rst_in), .ext_rst_n(ext_rst_n), .sw_rst_req(sw_rst_req),
    .rst_n_out(a_out), .busy(a_busy), .rst_cause(a_cause)
  );

  reset_sequencer #(.NUM_CH(B_NCH), .HOLD_TICKS(B_H), .STAGE_TICKS(B_ST), .SYNC_STAGES(B_S)) u_b (
    .clk(clk), .rst_in(rst_in), .ext_rst_n(ext_rst_n), .sw_rst_req(sw_rst_req),
    .rst_n_out(b_out), .busy(b_busy), .rst_cause(b_cause)
  );

  // Reference model: t0 is the last edge at which any reset cause was in force;
  // channel k of an instance is released from edge t0 + HOLD + k*STAGE onward.
  int P_NCH [2] = '{A_NCH, B_NCH};
  int P_H   [2] = '{A_H,   B_H};
  int P_ST  [2] = '{A_ST,  B_ST};
  int P_S   [2] = '{A_S,   B_S};

  int         n;
  int         t0 [2];
  logic [1:0] m_cause [2];
  bit         ext_hist [0:HIST-1];

  typedef struct {
    int         edge_n;
    bit         sw;
    logic [3:0] a_out;
    bit         a_busy;
    bit         b_out;
    bit         b_busy;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t edge=%0d got=%0h expected=%0h", name, $time, n, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_out(input int i);
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < P_NCH[i]; k++)
      if (n >= t0[i] + P_H[i] + k * P_ST[i]) r[k] = 1'b1;
    return r;
  endfunction

  task automatic model_step(input int i);
    bit ext_low;
    bit in_hold;
    ext_low = (n > P_S[i]) && !ext_hist[n - P_S[i]];
    in_hold = (n - 1) < (t0[i] + P_H[i]);
    if (ext_low) begin
      if (n > t0[i]) t0[i] = n;
      m_cause[i] = 2'b01;
    end else if (sw_rst_req && !in_hold) begin
      t0[i] = n;
      m_cause[i] = 2'b10;
    end
  endtask

  task automatic check_all();
    logic [3:0] ea;
    logic [3:0] eb;
    ea = exp_out(0);
    eb = exp_out(1);
    check("a_rst_n_out", 32'(a_out), 32'(ea));
    check("a_busy", 32'(a_busy), 32'(ea != 4'hF));
    check("a_cause", 32'(a_cause), 32'(m_cause[0]));
    check("b_rst_n_out", 32'(b_out), 32'(eb[0]));
    check("b_busy", 32'(b_busy), 32'(!eb[0]));
    check("b_cause", 32'(b_cause), 32'(m_cause[1]));
  endtask

  // One clock: model advances at the rising edge, DUT is compared at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst_in) begin
      n = 0;
      t0[0] = A_S;
      t0[1] = B_S;
      m_cause[0] = 2'b00;
      m_cause[1] = 2'b00;
    end else begin
      n++;
      if (n < HIST) ext_hist[n] = ext_rst_n;
      model_step(0);
      model_step(1);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic run_power_on();
    rst_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      while (n < vecs[i].edge_n - 1) tick();
      sw_rst_req = vecs[i].sw;
      tick();
      sw_rst_req = 1'b0;
      check("tbl_a_out", 32'(a_out), 32'(vecs[i].a_out));
      check("tbl_a_busy", 32'(a_busy), 32'(vecs[i].a_busy));
      check("tbl_b_out", 32'(b_out), 32'(vecs[i].b_out));
      check("tbl_b_busy", 32'(b_busy), 32'(vecs[i].b_busy));
      check("tbl_a_cause", 32'(a_cause), 32'(2'b00));
      check("tbl_b_cause", 32'(b_cause), 32'(2'b00));
    end
  endtask

  initial begin
    int j, m, p;
    int ext_left, rst_left;

    vecs[0]  = '{1,  1'b0, 4'b0000, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{2,  1'b1, 4'b0000, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{3,  1'b0, 4'b0000, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{4,  1'b0, 4'b0000, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{33, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{34, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{49, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{50, 1'b0, 4'b0011, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{65, 1'b0, 4'b0011, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{66, 1'b0, 4'b0111, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{81, 1'b0, 4'b0111, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{82, 1'b0, 4'b1111, 1'b0, 1'b1, 1'b0};

    rst_in = 1'b1;
    ext_rst_n = 1'b1;
    sw_rst_req = 1'b0;
    n = 0;
    tick();
    tick();
    check("por_a_out", 32'(a_out), 32'(0));
    check("por_a_busy", 32'(a_busy), 32'(1));

    // Power-on timing, including a software request ignored during HOLD.
    run_power_on();

    // Software reset from RUN.
    repeat (5) tick();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    j = n;
    check("sw_a_out", 32'(a_out), 32'(0));
    check("sw_a_busy", 32'(a_busy), 32'(1));
    check("sw_a_cause", 32'(a_cause), 32'(2'b10));
    check("sw_b_out", 32'(b_out), 32'(0));
    check("sw_b_cause", 32'(b_cause), 32'(2'b10));
    tick();
    check("sw_b_rel", 32'(b_out), 32'(1));
    while (n < j + 31) tick();
    check("sw_a_hold", 32'(a_out), 32'(0));
    tick();
    check("sw_a_ch0", 32'(a_out), 32'(4'b0001));
    while (n < j + 80) tick();
    check("sw_a_run", 32'(a_out), 32'(4'b1111));
    check("sw_a_idle", 32'(a_busy), 32'(0));

    // External reset held 100 cycles during RELEASE.
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    j = n;
    while (n < j + 32) tick();
    check("ext_pre_ch0", 32'(a_out), 32'(4'b0001));
    repeat (3) tick();
    ext_rst_n = 1'b0;
    m = n + 1;
    repeat (3) tick();
    check("ext_a_low", 32'(a_out), 32'(0));
    check("ext_a_busy", 32'(a_busy), 32'(1));
    check("ext_a_cause", 32'(a_cause), 32'(2'b01));
    repeat (97) begin
      tick();
      check("ext_held_low", 32'(a_out), 32'(0));
    end
    ext_rst_n = 1'b1;
    p = n + 1;
    while (n < p + 32) tick();
    check("ext_a_hold", 32'(a_out), 32'(0));
    tick();
    check("ext_a_ch0", 32'(a_out), 32'(4'b0001));
    check("ext_a_cause2", 32'(a_cause), 32'(2'b01));

    // Software request on the edge the synchronised external reset first reads low.
    while (n < p + 81) tick();
    check("sim_a_run", 32'(a_out), 32'(4'b1111));
    ext_rst_n = 1'b0;
    m = n + 1;
    tick();
    tick();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    ext_rst_n = 1'b1;
    check("sim_a_out", 32'(a_out), 32'(0));
    check("sim_a_cause", 32'(a_cause), 32'(2'b01));
    while (n < m + 35) tick();
    check("sim_a_hold", 32'(a_out), 32'(0));
    tick();
    check("sim_a_ch0", 32'(a_out), 32'(4'b0001));
    check("sim_a_cause2", 32'(a_cause), 32'(2'b01));

    // rst_in mid-sequence after ch1 release.
    while (n < m + 53) tick();
    check("mid_a_ch1", 32'(a_out), 32'(4'b0011));
    #3 rst_in = 1'b1;
    #1;
    check("mid_a_async", 32'(a_out), 32'(0));
    check("mid_a_busy", 32'(a_busy), 32'(1));
    check("mid_a_cause", 32'(a_cause), 32'(2'b00));
    check("mid_b_async", 32'(b_out), 32'(0));
    check("mid_b_cause", 32'(b_cause), 32'(2'b00));
    tick();
    tick();
    run_power_on();

    // Random mix of software pulses, external bursts and power-on resets.
    ext_left = 0;
    rst_left = 0;
    for (int c = 0; c < 4000; c++) begin
      sw_rst_req = ($urandom_range(0, 149) == 0);
      if (ext_left > 0) ext_left--;
      else if ($urandom_range(0, 399) == 0) ext_left = $urandom_range(1, 40);
      ext_rst_n = (ext_left == 0);
      if (rst_left > 0) rst_left--;
      else if ($urandom_range(0, 1999) == 0) rst_left = $urandom_range(1, 3);
      rst_in = (rst_left != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
